// File: rtl/instr_fetch_unit_if.sv
// Bus between the instruction fetch unit, its program ROM and the execute stage.
// The master modport is the fetch unit's side; the slave modport is the environment's side.
interface instr_fetch_unit_if;
  logic [7:0] rom_address;
  logic [7:0] rom_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic       instr_has_operand;
  logic [7:0] instr_pc;
  logic       instr_illegal;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       fetch_fault;

  modport master (
    output rom_address,
    input  rom_data,
    output instr_valid,
    input  instr_ready,
    output instr_opcode,
    output instr_operand,
    output instr_has_operand,
    output instr_pc,
    output instr_illegal,
    input  branch_taken,
    input  branch_target,
    output fetch_fault
  );

  modport slave (
    input  rom_address,
    output rom_data,
    input  instr_valid,
    output instr_ready,
    input  instr_opcode,
    input  instr_operand,
    input  instr_has_operand,
    input  instr_pc,
    input  instr_illegal,
    output branch_taken,
    output branch_target,
    input  fetch_fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads one- or two-byte instructions from a synchronous ROM,
// issues them to the execute stage with a valid/ready handshake, and supports redirects.
module instr_fetch_unit (
  input logic                 clk,
  input logic                 reset_n,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {
    StFetchOp,
    StLatchOp,
    StFetchOpnd,
    StLatchOpnd,
    StIssue,
    StFault
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic       has_opnd_q, has_opnd_d;
  logic [7:0] ipc_q, ipc_d;
  logic       illegal_q, illegal_d;
  logic       fault_q, fault_d;

  logic       op_two_byte;
  logic       op_one_byte;

  // Decode the byte arriving from the ROM; only meaningful in StLatchOp.
  always_comb begin
    op_two_byte = ((bus.rom_data >= 8'h10) && (bus.rom_data <= 8'h15)) ||
                  ((bus.rom_data >= 8'h30) && (bus.rom_data <= 8'h38));
    op_one_byte = (bus.rom_data >= 8'h20) && (bus.rom_data <= 8'h27);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    has_opnd_d = has_opnd_q;
    ipc_d      = ipc_q;
    illegal_d  = illegal_q;
    fault_d    = fault_q;

    if (bus.branch_taken) begin
      // Redirect wins over everything; a bundle accepted this edge is already gone.
      state_d = StFetchOp;
      pc_d    = bus.branch_target;
      fault_d = 1'b0;
    end else begin
      unique case (state_q)
        StFetchOp, StFetchOpnd: begin
          if (pc_q >= 8'h80) begin
            state_d = StFault;
            fault_d = 1'b1;
          end else begin
            state_d = (state_q == StFetchOp) ? StLatchOp : StLatchOpnd;
          end
        end
        StLatchOp: begin
          opcode_d   = bus.rom_data;
          operand_d  = 8'h00;
          ipc_d      = pc_q;
          pc_d       = pc_q + 8'd1;
          has_opnd_d = op_two_byte;
          illegal_d  = !(op_two_byte || op_one_byte);
          state_d    = op_two_byte ? StFetchOpnd : StIssue;
        end
        StLatchOpnd: begin
          operand_d = bus.rom_data;
          pc_d      = pc_q + 8'd1;
          state_d   = StIssue;
        end
        StIssue: begin
          if (bus.instr_ready) begin
            state_d = StFetchOp;
          end
        end
        StFault: begin
          state_d = StFault;
        end
        default: begin
          state_d = StFetchOp;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StFetchOp;
      pc_q       <= 8'h00;
      opcode_q   <= 8'h00;
      operand_q  <= 8'h00;
      has_opnd_q <= 1'b0;
      ipc_q      <= 8'h00;
      illegal_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      has_opnd_q <= has_opnd_d;
      ipc_q      <= ipc_d;
      illegal_q  <= illegal_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.rom_address       = pc_q;
  assign bus.instr_valid       = (state_q == StIssue);
  assign bus.instr_opcode      = opcode_q;
  assign bus.instr_operand     = operand_q;
  assign bus.instr_has_operand = has_opnd_q;
  assign bus.instr_pc          = ipc_q;
  assign bus.instr_illegal     = illegal_q;
  assign bus.fetch_fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios, then random programs, readiness and
// redirects checked against an instruction-level model of the fetch sequence.
module tb_instr_fetch_unit;
  logic clk;
  logic reset_n;
  instr_fetch_unit_if bus ();

  instr_fetch_unit u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0] rom [256];
  int errors = 0;
  int checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM: data for the address sampled on an edge appears in the next cycle.
  always @(posedge clk) bus.rom_data <= rom[bus.rom_address];

  function automatic bit is_two(input logic [7:0] op);
    return ((op >= 8'h10) && (op <= 8'h15)) || ((op >= 8'h30) && (op <= 8'h38));
  endfunction

  function automatic bit is_legal(input logic [7:0] op);
    return is_two(op) || ((op >= 8'h20) && (op <= 8'h27));
  endfunction

  // An instruction at pc cannot be fully fetched if any of its bytes lies at or above 0x80.
  function automatic bit fault_pred(input logic [7:0] pc);
    return (pc >= 8'h80) || ((pc == 8'h7F) && is_two(rom[8'h7F]));
  endfunction

  function automatic logic [7:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 8'h10 + 8'($urandom_range(0, 5));
      1:       return 8'h30 + 8'($urandom_range(0, 8));
      2:       return 8'h20 + 8'($urandom_range(0, 7));
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_bundle(input string tag, input logic [7:0] op, input logic [7:0] opnd,
                            input logic has, input logic [7:0] pc, input logic ill);
    chk({tag, ".valid"}, 32'(bus.instr_valid), 32'd1);
    chk({tag, ".opcode"}, 32'(bus.instr_opcode), 32'(op));
    chk({tag, ".operand"}, 32'(bus.instr_operand), 32'(opnd));
    chk({tag, ".has_operand"}, 32'(bus.instr_has_operand), 32'(has));
    chk({tag, ".pc"}, 32'(bus.instr_pc), 32'(pc));
    chk({tag, ".illegal"}, 32'(bus.instr_illegal), 32'(ill));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".rom_address"}, 32'(bus.rom_address), 32'h00);
    chk({tag, ".valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, ".opcode"}, 32'(bus.instr_opcode), 32'h00);
    chk({tag, ".operand"}, 32'(bus.instr_operand), 32'h00);
    chk({tag, ".has_operand"}, 32'(bus.instr_has_operand), 32'd0);
    chk({tag, ".pc"}, 32'(bus.instr_pc), 32'h00);
    chk({tag, ".illegal"}, 32'(bus.instr_illegal), 32'd0);
    chk({tag, ".fault"}, 32'(bus.fetch_fault), 32'd0);
  endtask

  initial begin
    int unsigned idle;
    logic [7:0]  mpc;
    logic [7:0]  exp_op;
    logic [7:0]  exp_opnd;
    logic        held;
    logic [7:0]  h_op, h_opnd, h_pc;
    logic        h_has, h_ill;
    logic        rdy, br;
    logic [7:0]  tgt;

    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h10;
    rom[8'h01] = 8'hAA;
    rom[8'h02] = 8'h20;
    rom[8'h03] = 8'h11;
    rom[8'h04] = 8'h77;
    rom[8'h0F] = 8'hFF;
    rom[8'h10] = 8'h21;

    reset_n = 1'b0;
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 8'h00;
    step(2);
    chk_reset_outputs("reset");

    // Two-byte instruction from 0x00: bundle in cycle 4 after release.
    reset_n = 1'b1;
    chk("c0.addr", 32'(bus.rom_address), 32'h00);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk("c1_3.valid", 32'(bus.instr_valid), 32'd0);
    end
    step();
    chk_bundle("two_byte", 8'h10, 8'hAA, 1'b1, 8'h00, 1'b0);
    chk("two_byte.next_addr", 32'(bus.rom_address), 32'h02);

    // One-byte instruction, then hold it under back-pressure for three cycles.
    step();
    chk("one_byte.fetch_valid", 32'(bus.instr_valid), 32'd0);
    chk("one_byte.fetch_addr", 32'(bus.rom_address), 32'h02);
    step();
    bus.instr_ready = 1'b0;
    step();
    for (int c = 0; c < 4; c++) begin
      chk_bundle("stall", 8'h20, 8'h00, 1'b0, 8'h02, 1'b0);
      chk("stall.addr", 32'(bus.rom_address), 32'h03);
      if (c == 3) bus.instr_ready = 1'b1;
      step();
    end
    chk("stall.release_valid", 32'(bus.instr_valid), 32'd0);
    chk("stall.release_addr", 32'(bus.rom_address), 32'h03);

    // Redirect during LATCH_OP of a two-byte opcode at 0x03.
    step();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h0F;
    step();
    bus.branch_taken = 1'b0;
    chk("redir.addr", 32'(bus.rom_address), 32'h0F);
    chk("redir.valid0", 32'(bus.instr_valid), 32'd0);
    step();
    chk("redir.valid1", 32'(bus.instr_valid), 32'd0);
    step();
    chk_bundle("illegal", 8'hFF, 8'h00, 1'b0, 8'h0F, 1'b1);
    step();
    chk("illegal.next_addr", 32'(bus.rom_address), 32'h10);

    // Branch out of range: fault two cycles later, cleared by branching back to 0x00.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h80;
    step();
    bus.branch_taken = 1'b0;
    chk("fault.addr", 32'(bus.rom_address), 32'h80);
    chk("fault.early", 32'(bus.fetch_fault), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("fault.flag", 32'(bus.fetch_fault), 32'd1);
      chk("fault.valid", 32'(bus.instr_valid), 32'd0);
      chk("fault.pc_frozen", 32'(bus.rom_address), 32'h80);
    end
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h00;
    step();
    bus.branch_taken = 1'b0;
    chk("unfault.flag", 32'(bus.fetch_fault), 32'd0);
    chk("unfault.addr", 32'(bus.rom_address), 32'h00);
    step(4);
    chk_bundle("refetch", 8'h10, 8'hAA, 1'b1, 8'h00, 1'b0);

    // Asynchronous reset while a bundle is stalled in ISSUE.
    bus.instr_ready = 1'b0;
    step();
    chk("pre_reset.valid", 32'(bus.instr_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    step();
    reset_n = 1'b1;
    bus.instr_ready = 1'b1;
    step(4);
    chk_bundle("post_reset", 8'h10, 8'hAA, 1'b1, 8'h00, 1'b0);

    // Random programs, back-pressure and redirects against an instruction-level model.
    for (int i = 0; i < 256; i++) rom[i] = rnd_op();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    mpc  = 8'h00;
    idle = 0;
    held = 1'b0;
    h_op = 8'h00; h_opnd = 8'h00; h_pc = 8'h00; h_has = 1'b0; h_ill = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 39) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 8'h80 + 8'($urandom_range(0, 127))
                                        : 8'($urandom_range(0, 127));
      bus.instr_ready   = rdy;
      bus.branch_taken  = br;
      bus.branch_target = tgt;

      if (held) begin
        chk_bundle("rnd.hold", h_op, h_opnd, h_has, h_pc, h_ill);
      end
      if (bus.instr_valid && rdy) begin
        exp_op   = rom[mpc];
        exp_opnd = is_two(exp_op) ? rom[8'(mpc + 8'd1)] : 8'h00;
        chk("rnd.no_fault_expected", 32'(fault_pred(mpc)), 32'd0);
        chk_bundle("rnd.accept", exp_op, exp_opnd, is_two(exp_op), mpc, !is_legal(exp_op));
        mpc = is_two(exp_op) ? 8'(mpc + 8'd2) : 8'(mpc + 8'd1);
      end
      if (bus.fetch_fault) begin
        chk("rnd.fault_valid", 32'(bus.instr_valid), 32'd0);
        chk("rnd.fault_expected", 32'(fault_pred(mpc)), 32'd1);
      end
      if (bus.instr_valid || bus.fetch_fault || br) idle = 0;
      else idle++;
      chk("rnd.progress", 32'(idle <= 5), 32'd1);

      held   = bus.instr_valid && !rdy && !br;
      h_op   = bus.instr_opcode;
      h_opnd = bus.instr_operand;
      h_has  = bus.instr_has_operand;
      h_pc   = bus.instr_pc;
      h_ill  = bus.instr_illegal;
      if (br) mpc = tgt;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port rom_address  out  8  program ROM address; combinational copy of the PC register.
REQ-004 SHALL have port rom_data  in  8  ROM read data, valid in the cycle after the edge that sampled rom_address.
REQ-005 SHALL have port instr_valid  out  1  instruction bundle valid to execute stage.
REQ-006 SHALL have port instr_ready  in  1  execute stage accepts bundle.
REQ-007 SHALL have port instr_opcode  out  8  fetched opcode.
REQ-008 SHALL have port instr_operand  out  8  fetched operand byte; 0x00 for one-byte instructions.
REQ-009 SHALL have port instr_has_operand  out  1  bundle carries an operand.
REQ-010 SHALL have port instr_pc  out  8  address of the opcode byte.
REQ-011 SHALL have port instr_illegal  out  1  opcode not in instruction set.
REQ-012 SHALL have port branch_taken  in  1  redirect request, single-cycle strobe.
REQ-013 SHALL have port branch_target  in  8  redirect address, sampled with branch_taken.
REQ-014 SHALL have port fetch_fault  out  1  sticky out-of-range fetch indication.

Function
REQ-015 SHALL implement states FETCH_OP, LATCH_OP, FETCH_OPND, LATCH_OPND, ISSUE, FAULT.
REQ-016 FETCH_OP: if PC >= 0x80 go FAULT, else go LATCH_OP (ROM samples PC on this edge).
REQ-017 LATCH_OP: capture rom_data into opcode register, instr_pc <= PC, PC <= PC+1; go FETCH_OPND if two-byte, else ISSUE with operand 0x00.
REQ-018 Two-byte opcodes SHALL be 0x10-0x15 and 0x30-0x38; one-byte legal opcodes 0x20-0x27.
REQ-019 Any other opcode SHALL be treated as one-byte with instr_illegal=1 in its bundle.
REQ-020 FETCH_OPND: if PC >= 0x80 go FAULT, else go LATCH_OPND.
REQ-021 LATCH_OPND: capture rom_data into operand register, PC <= PC+1, go ISSUE.
REQ-022 ISSUE: instr_valid=1; bundle outputs SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-023 ISSUE with instr_ready=1: transfer completes on that edge; go FETCH_OP; instr_valid=0 next cycle.
REQ-024 instr_valid SHALL be 1 only in ISSUE; bundle latency from FETCH_OP entry: 2 cycles one-byte, 4 cycles two-byte.
REQ-025 PC arithmetic SHALL be 8-bit modulo (0xFF+1 = 0x00).
REQ-026 branch_taken=1 in any state: PC <= branch_target, state <= FETCH_OP, fetch_fault <= 0, any partial or pending bundle discarded.
REQ-027 branch_taken with a completing transfer in the same cycle: transfer counts as accepted, redirect still applied, no old-path bundle follows.
REQ-028 FAULT: fetch_fault=1, instr_valid=0, PC frozen; exited only by branch_taken or reset.

Reset
REQ-029 reset_n=0 SHALL immediately force state FETCH_OP, PC 0x00, rom_address 0x00, instr_valid 0, instr_opcode 0x00, instr_operand 0x00, instr_has_operand 0, instr_pc 0x00, instr_illegal 0, fetch_fault 0.
REQ-030 Reset asserted mid-fetch or mid-ISSUE SHALL discard the bundle; after release, fetch restarts at 0x00 with FETCH_OP in the first cycle.

Verification
REQ-031 ROM[0..1]=0x10,0xAA, ready=1 -> instr_valid in cycle 4 after reset release with opcode 0x10, operand 0xAA, has_operand 1, instr_pc 0x00; next rom_address 0x02.
REQ-032 ROM[2]=0x20 -> valid 2 cycles after FETCH_OP entry, opcode 0x20, operand 0x00, has_operand 0, instr_pc 0x02.
REQ-033 instr_ready held 0 for 3 cycles in ISSUE -> bundle and rom_address unchanged; transfer on 4th cycle when ready=1.
REQ-034 branch_taken=1, target 0x0F during LATCH_OP of a two-byte opcode -> rom_address 0x0F next cycle, no bundle from old address; ROM[0x0F]=0xFF then issues with instr_illegal=1, has_operand 0, instr_pc 0x0F.
REQ-035 Branch to 0x80 -> fetch_fault=1 two cycles later, instr_valid stays 0; branch to 0x00 clears fault and fetches 0x00.
REQ-036 reset_n pulsed low during ISSUE with ready=0 -> all outputs at reset values asynchronously; refetch from 0x00 after release.
